// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: two-port req/ack arbiter for the data memory with alignment and range checks.
// Define DM_ARB_ROUND_ROBIN_EN to alternate ties between ports; otherwise port A has fixed priority.
module dm_port_arbiter #(
    parameter int MEM_BYTES = 8192,
    parameter int ADDR_W    = 32
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [1:0]        a_size,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [31:0]       a_wdata,
    output logic [31:0]       a_rdata,
    output logic              a_ack,
    output logic              a_err,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [1:0]        b_size,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [31:0]       b_wdata,
    output logic [31:0]       b_rdata,
    output logic              b_ack,
    output logic              b_err,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_wdata,
    output logic              dm_we,
    output logic              dm_byte,
    output logic              dm_hbyte,
    input  logic [31:0]       dm_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    localparam logic [ADDR_W:0] MEM_LIM = (ADDR_W+1)'(MEM_BYTES);
    state_t state;
    logic sel, cmd_we, cmd_err;
    logic grant_b, g_we, g_err;
    logic [1:0] g_size;
    logic [ADDR_W-1:0] g_addr;
    logic [31:0] g_wdata;
    logic [ADDR_W:0] g_bytes, g_end;
`ifdef DM_ARB_ROUND_ROBIN_EN
    logic last_b;
    assign grant_b = b_req & (~a_req | ~last_b);
`else
    assign grant_b = b_req & ~a_req;
`endif
    // End address is one bit wider than the request so high addresses cannot wrap into range.
    always_comb begin
        g_we    = grant_b ? b_we : a_we;
        g_size  = grant_b ? b_size : a_size;
        g_addr  = grant_b ? b_addr : a_addr;
        g_wdata = grant_b ? b_wdata : a_wdata;
        g_bytes = g_size == 2'b00 ? (ADDR_W+1)'(1) : g_size == 2'b01 ? (ADDR_W+1)'(2) : (ADDR_W+1)'(4);
        g_end   = {1'b0, g_addr} + g_bytes;
        g_err   = (g_size == 2'b11) | (g_size == 2'b01 & g_addr[0]) |
                  (g_size == 2'b10 & |g_addr[1:0]) | (g_end > MEM_LIM);
    end
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            sel      <= 1'b0;
            cmd_we   <= 1'b0;
            cmd_err  <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
            a_ack    <= 1'b0;
            b_ack    <= 1'b0;
            a_err    <= 1'b0;
            b_err    <= 1'b0;
            dm_addr  <= '0;
            dm_wdata <= '0;
            dm_we    <= 1'b0;
            dm_byte  <= 1'b0;
            dm_hbyte <= 1'b0;
`ifdef DM_ARB_ROUND_ROBIN_EN
            last_b   <= 1'b1;
`endif
        end else begin
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            a_err <= 1'b0;
            b_err <= 1'b0;
            case (state)
                IDLE: if (a_req | b_req) begin
                    state    <= ACCESS;
                    sel      <= grant_b;
                    cmd_we   <= g_we;
                    cmd_err  <= g_err;
                    dm_addr  <= g_err ? '0 : g_addr;
                    dm_wdata <= g_err ? '0 : g_wdata;
                    dm_we    <= g_we & ~g_err;
                    dm_byte  <= ~g_err & (g_size == 2'b00);
                    dm_hbyte <= ~g_err & (g_size == 2'b01);
`ifdef DM_ARB_ROUND_ROBIN_EN
                    last_b   <= grant_b;
`endif
                end
                ACCESS: begin
                    state    <= RESP;
                    dm_addr  <= '0;
                    dm_wdata <= '0;
                    dm_we    <= 1'b0;
                    dm_byte  <= 1'b0;
                    dm_hbyte <= 1'b0;
                    a_ack    <= ~sel;
                    b_ack    <= sel;
                    a_err    <= ~sel & cmd_err;
                    b_err    <= sel & cmd_err;
                    if ((cmd_err | ~cmd_we) & ~sel) a_rdata <= cmd_err ? '0 : dm_rdata;
                    if ((cmd_err | ~cmd_we) & sel) b_rdata <= cmd_err ? '0 : dm_rdata;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb_dm_port_arbiter: vector table plus corner sequences for dm_port_arbiter, against a byte memory model.
// Tie-break expectations follow DM_ARB_ROUND_ROBIN_EN when it is defined for the build.
module tb_dm_port_arbiter;
    logic Clk = 1'b0, Reset_n = 1'b0, clr = 1'b1;
    logic a_req = 0, a_we = 0, b_req = 0, b_we = 0;
    logic [1:0] a_size = 0, b_size = 0;
    logic [31:0] a_addr = 0, a_wdata = 0, b_addr = 0, b_wdata = 0;
    logic [31:0] a_rdata, b_rdata, dm_addr, dm_wdata, dm_rdata;
    logic a_ack, a_err, b_ack, b_err, dm_we, dm_byte, dm_hbyte;
    logic [7:0] mem [0:8191];
    logic [7:0] b0, b1, b2, b3;
    logic err_active = 1'b0;
    int checks = 0, failures = 0;

    typedef struct {logic port; logic chk; logic [31:0] rdata; logic err;} exp_t;
    typedef struct {logic port; logic we; logic [1:0] size; logic [31:0] addr; logic [31:0] wdata; logic [31:0] rdata; logic err;} vec_t;
    exp_t sb[$];
    vec_t vt[20];

    dm_port_arbiter dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .a_req(a_req), .a_we(a_we), .a_size(a_size), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata), .a_ack(a_ack), .a_err(a_err),
        .b_req(b_req), .b_we(b_we), .b_size(b_size), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(b_rdata), .b_ack(b_ack), .b_err(b_err),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_byte(dm_byte),
        .dm_hbyte(dm_hbyte), .dm_rdata(dm_rdata)
    );

    always #5 Clk = ~Clk;

    // Little-endian byte memory, sign-extending reads like the real data memory.
    always @(posedge Clk) begin
        if (clr) begin
            for (int i = 0; i < 8192; i++) mem[i] <= 8'h00;
        end else if (dm_we) begin
            mem[dm_addr[12:0]] <= dm_wdata[7:0];
            if (!dm_byte) mem[dm_addr[12:0] + 13'd1] <= dm_wdata[15:8];
            if (!dm_byte && !dm_hbyte) begin
                mem[dm_addr[12:0] + 13'd2] <= dm_wdata[23:16];
                mem[dm_addr[12:0] + 13'd3] <= dm_wdata[31:24];
            end
        end
    end
    assign b0 = mem[dm_addr[12:0]];
    assign b1 = mem[dm_addr[12:0] + 13'd1];
    assign b2 = mem[dm_addr[12:0] + 13'd2];
    assign b3 = mem[dm_addr[12:0] + 13'd3];
    assign dm_rdata = dm_byte ? {{24{b0[7]}}, b0} : dm_hbyte ? {{16{b1[7]}}, b1, b0} : {b3, b2, b1, b0};

    always @(negedge Clk) begin
        if (Reset_n && err_active && dm_we) begin
            checks++;
            failures++;
            $display("FAIL err_no_mem dm_we=1 required=0 at %0t", $time);
        end
        if (Reset_n && dm_byte && dm_hbyte) begin
            checks++;
            failures++;
            $display("FAIL size_excl dm_byte=1 dm_hbyte=1 at %0t", $time);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req_v, $time);
        end
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected_ack a_ack=%b b_ack=%b", a_ack, b_ack);
            return;
        end
        e = sb.pop_front();
        chk("ack_port", 32'(b_ack), 32'(e.port));
        chk("ack_both", 32'(a_ack & b_ack), 32'd0);
        chk("ack_err", 32'(e.port ? b_err : a_err), 32'(e.err));
        if (e.chk) chk("rdata", e.port ? b_rdata : a_rdata, e.rdata);
    endtask

    task automatic access(input vec_t v);
        int cyc;
        @(negedge Clk);
        if (v.port) begin
            b_req = 1; b_we = v.we; b_size = v.size; b_addr = v.addr; b_wdata = v.wdata;
        end else begin
            a_req = 1; a_we = v.we; a_size = v.size; a_addr = v.addr; a_wdata = v.wdata;
        end
        err_active = v.err;
        sb.push_back('{v.port, !v.we, v.rdata, v.err});
        @(negedge Clk);
        cyc = 1;
        chk("dm_we", 32'(dm_we), 32'(v.we & !v.err));
        chk("dm_addr", dm_addr, v.err ? 32'd0 : v.addr);
        chk("dm_size", 32'({dm_byte, dm_hbyte}), v.err ? 32'd0 : v.size == 2'b00 ? 32'd2 : v.size == 2'b01 ? 32'd1 : 32'd0);
        while (!(a_ack | b_ack) && cyc < 8) begin
            @(negedge Clk);
            cyc++;
        end
        chk("latency", 32'(cyc), 32'd2);
        if (a_ack | b_ack) pop_check();
        else if (sb.size() > 0) sb.delete(0);
        a_req = 0;
        b_req = 0;
        @(negedge Clk);
        chk("ack_pulse", 32'(a_ack | b_ack), 32'd0);
        err_active = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int n, last, cyc;
        logic rr;
`ifdef DM_ARB_ROUND_ROBIN_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        //          port we  size   addr           wdata          rdata          err
        vt[0]  = '{1'b0, 1, 2'd2, 32'h0000_0010, 32'hDEADBEEF, 32'h0,        0};
        vt[1]  = '{1'b0, 0, 2'd2, 32'h0000_0010, 32'h0,        32'hDEADBEEF, 0};
        vt[2]  = '{1'b1, 1, 2'd0, 32'h0000_0021, 32'h0000_0080, 32'h0,       0};
        vt[3]  = '{1'b1, 0, 2'd0, 32'h0000_0021, 32'h0,        32'hFFFFFF80, 0};
        vt[4]  = '{1'b1, 0, 2'd2, 32'h0000_0020, 32'h0,        32'h0000_8000, 0};
        vt[5]  = '{1'b0, 0, 2'd1, 32'h0000_0003, 32'h0,        32'h0,        1};
        vt[6]  = '{1'b0, 1, 2'd2, 32'h0000_0102, 32'h12345678, 32'h0,        1};
        vt[7]  = '{1'b0, 0, 2'd2, 32'h0000_1FFE, 32'h0,        32'h0,        1};
        vt[8]  = '{1'b0, 0, 2'd2, 32'h0000_0100, 32'h0,        32'h0,        0};
        vt[9]  = '{1'b0, 1, 2'd1, 32'h0000_1FFE, 32'h0000_A5C3, 32'h0,       0};
        vt[10] = '{1'b0, 0, 2'd1, 32'h0000_1FFE, 32'h0,        32'hFFFFA5C3, 0};
        vt[11] = '{1'b1, 1, 2'd0, 32'h0000_2000, 32'h0000_0077, 32'h0,       1};
        vt[12] = '{1'b1, 0, 2'd0, 32'hFFFF_FFFF, 32'h0,        32'h0,        1};
        vt[13] = '{1'b0, 0, 2'd2, 32'h0000_1FFC, 32'h0,        32'hA5C30000, 0};
        vt[14] = '{1'b0, 1, 2'd0, 32'h0000_1FFF, 32'h0000_0011, 32'h0,       0};
        vt[15] = '{1'b0, 0, 2'd2, 32'h0000_1FFC, 32'h0,        32'h11C30000, 0};
        vt[16] = '{1'b0, 0, 2'd3, 32'h0000_0040, 32'h0,        32'h0,        1};
        vt[17] = '{1'b1, 1, 2'd2, 32'h0000_0044, 32'hCAFEF00D, 32'h0,        0};
        vt[18] = '{1'b0, 0, 2'd1, 32'h0000_0046, 32'h0,        32'hFFFFCAFE, 0};
        vt[19] = '{1'b1, 0, 2'd1, 32'h0000_0044, 32'h0,        32'hFFFFF00D, 0};

        repeat (2) @(posedge Clk);
        clr = 1'b0;
        @(negedge Clk);
        chk("rst_acks", 32'({a_ack, b_ack, a_err, b_err}), 32'd0);
        chk("rst_a_rdata", a_rdata, 32'd0);
        chk("rst_b_rdata", b_rdata, 32'd0);
        chk("rst_dm_addr", dm_addr, 32'd0);
        chk("rst_dm_wdata", dm_wdata, 32'd0);
        chk("rst_dm_ctl", 32'({dm_we, dm_byte, dm_hbyte}), 32'd0);
        Reset_n = 1'b1;

        for (int i = 0; i < 20; i++) access(vt[i]);

        // Reset while a store is in its memory cycle: write must not commit, no ack.
        @(negedge Clk);
        a_req = 1; a_we = 1; a_size = 2'd2; a_addr = 32'h80; a_wdata = 32'h55AA55AA;
        @(negedge Clk);
        chk("abort_pre_we", 32'(dm_we), 32'd1);
        #1 Reset_n = 1'b0;
        #1;
        chk("abort_we", 32'(dm_we), 32'd0);
        chk("abort_addr", dm_addr, 32'd0);
        chk("abort_rdata", a_rdata, 32'd0);
        a_req = 0;
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            chk("abort_no_ack", 32'({a_ack, b_ack}), 32'd0);
        end
        access('{1'b0, 1'b0, 2'd2, 32'h80, 32'h0, 32'h0, 1'b0});

        // Fresh reset so the tie-break starts from its reset history.
        @(negedge Clk);
        Reset_n = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        a_req = 1; a_we = 0; a_size = 2'd2; a_addr = 32'h10;
        b_req = 1; b_we = 0; b_size = 2'd0; b_addr = 32'h21;
        for (int i = 0; i < 6; i++) begin
            logic p;
            p = rr & i[0];
            sb.push_back('{p, 1'b1, p ? 32'hFFFFFF80 : 32'hDEADBEEF, 1'b0});
        end
        n = 0;
        last = 0;
        for (cyc = 1; cyc <= 40 && n < 6; cyc++) begin
            @(negedge Clk);
            if (a_ack | b_ack) begin
                pop_check();
                if (n > 0) chk("b2b_gap", 32'(cyc - last), 32'd3);
                last = cyc;
                n++;
            end
        end
        chk("tie_count", 32'(n), 32'd6);
        a_req = 0;
        b_req = 0;
        sb.delete();

        // Single-cycle request still completes with one ack pulse.
        @(negedge Clk);
        @(negedge Clk);
        a_req = 1; a_we = 0; a_size = 2'd0; a_addr = 32'h21;
        sb.push_back('{1'b0, 1'b1, 32'hFFFFFF80, 1'b0});
        @(negedge Clk);
        a_req = 0;
        chk("pulse_early", 32'(a_ack), 32'd0);
        @(negedge Clk);
        chk("pulse_ack", 32'(a_ack), 32'd1);
        if (a_ack) pop_check();
        else sb.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            chk("pulse_once", 32'({a_ack, b_ack}), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
